// File: rtl/fb_wr_pkg.sv
// Shared types and helpers for the frame-buffer AXI burst writer.
package fb_wr_pkg;
  typedef enum logic [2:0] {IDLE, AW, W, B, DONE} wr_state_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/fb_wr_addr_gen.sv
// Tracks write progress inside a frame and the frame-buffer ring slot; produces
// the start address and length of the next burst from the post-update position.
module fb_wr_addr_gen import fb_wr_pkg::*; #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 28,
  parameter int BURST_LEN    = 16,
  parameter int FRAME_WORDS  = 1036800,
  parameter int FRAME_BASE   = 0,
  parameter int FRAME_STRIDE = 'h0080_0000,
  parameter int NUM_FRAMES   = 3,
  parameter int FIW          = clog2(NUM_FRAMES)
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  adv,
  input  logic                  restart,
  output logic [FIW-1:0]        frm_idx,
  output logic                  frame_full,
  output logic [ADDR_WIDTH-1:0] nxt_addr,
  output logic [7:0]            nxt_awlen
);
  localparam int CW = clog2(FRAME_WORDS + BURST_LEN + 1);
  localparam logic [CW-1:0] FW = CW'(FRAME_WORDS);
  localparam logic [CW-1:0] BL = CW'(BURST_LEN);

  logic [CW-1:0]  word_cnt, word_cnt_d;
  logic [FIW-1:0] frm_idx_d;

  function automatic logic [CW-1:0] burst_len(input logic [CW-1:0] wc);
    return ((FW - wc) < BL) ? (FW - wc) : BL;
  endfunction

  always_comb begin
    word_cnt_d = word_cnt;
    frm_idx_d  = frm_idx;
    if (restart) begin
      word_cnt_d = '0;
      frm_idx_d  = (frm_idx == FIW'(NUM_FRAMES - 1)) ? '0 : frm_idx + FIW'(1);
    end else if (adv) begin
      word_cnt_d = word_cnt + burst_len(word_cnt);
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      word_cnt <= '0;
      frm_idx  <= '0;
    end else begin
      word_cnt <= word_cnt_d;
      frm_idx  <= frm_idx_d;
    end
  end

  // Next-burst values come from the _d position so the FSM can latch them on
  // the same edge that advances the ring or the word count.
  assign frame_full = (word_cnt >= FW);
  assign nxt_awlen  = 8'(burst_len(word_cnt_d) - CW'(1));
  assign nxt_addr   = ADDR_WIDTH'(FRAME_BASE)
                    + ADDR_WIDTH'(frm_idx_d) * ADDR_WIDTH'(FRAME_STRIDE)
                    + ADDR_WIDTH'(word_cnt_d) * ADDR_WIDTH'(DATA_WIDTH / 8);
endmodule

// File: rtl/fb_axi_burst_writer.sv
// Drains prefetch-FIFO words into DDR as AXI4 INCR write bursts, one frame at a
// time into a ring of frame buffers; one burst outstanding at a time.
module fb_axi_burst_writer import fb_wr_pkg::*; #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 28,
  parameter int BURST_LEN    = 16,
  parameter int FRAME_WORDS  = 1036800,
  parameter int FRAME_BASE   = 0,
  parameter int FRAME_STRIDE = 'h0080_0000,
  parameter int NUM_FRAMES   = 3
) (
  input  logic                         rd_clk,
  input  logic                         rd_rst_n,
  input  logic                         frame_start,
  input  logic                         fifo_rd_vld,
  input  logic [DATA_WIDTH-1:0]        fifo_rd_data,
  output logic                         fifo_rd_en,
  output logic [ADDR_WIDTH-1:0]        m_awaddr,
  output logic [7:0]                   m_awlen,
  output logic                         m_awvalid,
  input  logic                         m_awready,
  output logic [DATA_WIDTH-1:0]        m_wdata,
  output logic [DATA_WIDTH/8-1:0]      m_wstrb,
  output logic                         m_wlast,
  output logic                         m_wvalid,
  input  logic                         m_wready,
  input  logic [1:0]                   m_bresp,
  input  logic                         m_bvalid,
  output logic                         m_bready,
  output logic                         frame_done,
  output logic [clog2(NUM_FRAMES)-1:0] done_frame_idx,
  output logic                         busy,
  output logic                         err
);
  localparam int FIW = clog2(NUM_FRAMES);

  wr_state_e             state;
  logic [7:0]            beat_cnt;
  logic                  pend, b_hs, restart, load_aw, frame_full;
  logic [FIW-1:0]        frm_idx;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [7:0]            nxt_awlen;

  // Write data is a straight pass-through of the FIFO head while in W.
  assign m_wvalid   = (state == W) & fifo_rd_vld;
  assign m_wdata    = (state == W) ? fifo_rd_data : '0;
  assign m_wstrb    = '1;
  assign m_wlast    = (state == W) & (beat_cnt == m_awlen);
  assign fifo_rd_en = m_wvalid & m_wready;
  assign b_hs       = m_bvalid & m_bready;
  assign busy       = (state != IDLE);

  // A start request seen during a frame abandons it once the in-flight burst is acknowledged.
  assign restart = (state == DONE) | (b_hs & (pend | frame_start));
  assign load_aw = (frame_start & ((state == IDLE) | (state == DONE)))
                 | (b_hs & (pend | frame_start | !frame_full));

  fb_wr_addr_gen #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .BURST_LEN(BURST_LEN),
    .FRAME_WORDS(FRAME_WORDS), .FRAME_BASE(FRAME_BASE), .FRAME_STRIDE(FRAME_STRIDE),
    .NUM_FRAMES(NUM_FRAMES), .FIW(FIW)
  ) u_addr_gen (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n),
    .adv(fifo_rd_en & m_wlast), .restart(restart),
    .frm_idx(frm_idx), .frame_full(frame_full),
    .nxt_addr(nxt_addr), .nxt_awlen(nxt_awlen)
  );

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state          <= IDLE;
      beat_cnt       <= '0;
      pend           <= 1'b0;
      m_awaddr       <= '0;
      m_awlen        <= '0;
      m_awvalid      <= 1'b0;
      m_bready       <= 1'b0;
      frame_done     <= 1'b0;
      done_frame_idx <= '0;
      err            <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_start && (state inside {AW, W, B})) begin
        err  <= 1'b1;
        pend <= 1'b1;
      end
      if (b_hs && (m_bresp != AXI_RESP_OKAY)) err <= 1'b1;
      case (state)
        IDLE: if (frame_start) state <= AW;
        AW: if (m_awready) begin
          m_awvalid <= 1'b0;
          beat_cnt  <= '0;
          state     <= W;
        end
        W: if (fifo_rd_en) begin
          beat_cnt <= beat_cnt + 8'd1;
          if (m_wlast) begin
            m_bready <= 1'b1;
            state    <= B;
          end
        end
        B: if (b_hs) begin
          m_bready <= 1'b0;
          if (pend || frame_start) begin
            pend  <= 1'b0;
            state <= AW;
          end else if (frame_full) begin
            frame_done     <= 1'b1;
            done_frame_idx <= frm_idx;
            state          <= DONE;
          end else begin
            state <= AW;
          end
        end
        DONE: state <= frame_start ? AW : IDLE;
        default: state <= IDLE;
      endcase
      if (load_aw) begin
        m_awvalid <= 1'b1;
        m_awaddr  <= nxt_addr;
        m_awlen   <= nxt_awlen;
      end
    end
  end
endmodule

// File: tb/tb_fb_axi_burst_writer.sv
// Directed-sequence bench with randomized data/backpressure; a queue-based
// FIFO and AXI slave model record traffic that is compared with a frame-level model.
module tb_fb_axi_burst_writer;
  localparam int DW = 32, AWW = 28, BL = 16, FW = 40, NF = 3, STRIDE = 'h1000;

  logic           rd_clk, rd_rst_n, frame_start;
  logic           fifo_rd_vld, fifo_rd_en;
  logic [DW-1:0]  fifo_rd_data;
  logic [AWW-1:0] m_awaddr;
  logic [7:0]     m_awlen;
  logic           m_awvalid, m_awready;
  logic [DW-1:0]  m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic           m_wlast, m_wvalid, m_wready;
  logic [1:0]     m_bresp;
  logic           m_bvalid, m_bready;
  logic           frame_done, busy, err;
  logic [1:0]     done_frame_idx;

  fb_axi_burst_writer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AWW), .BURST_LEN(BL), .FRAME_WORDS(FW),
    .FRAME_BASE(0), .FRAME_STRIDE(STRIDE), .NUM_FRAMES(NF)
  ) dut (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .frame_start(frame_start),
    .fifo_rd_vld(fifo_rd_vld), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .frame_done(frame_done), .done_frame_idx(done_frame_idx), .busy(busy), .err(err)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  int n_vec = 0, n_err = 0;
  logic [DW-1:0]    fifo_q[$], sent_q[$], w_q[$];
  logic [AWW+7:0]   aw_q[$], exp_aw[$];
  int               done_q[$];
  int aw_pct = 100, w_pct = 100, b_pct = 100;
  int b_owed = 0, b_idx = 0, err_b_idx = -1, beat = 0, cur_len = 0;
  bit b_clear = 0, aw_wait = 0;
  logic [AWW-1:0] aw_addr_prev;
  logic [7:0]     aw_len_prev;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO + AXI slave: drive inputs at negedge, then record the handshakes the next posedge will commit.
  always @(negedge rd_clk) begin
    if (!rd_rst_n) begin
      m_bvalid = 0; m_bresp = 0; m_awready = 0; m_wready = 0;
      fifo_rd_vld = 0; fifo_rd_data = '0;
      b_owed = 0; b_clear = 0; aw_wait = 0; beat = 0;
    end else begin
      if (b_clear) begin m_bvalid = 0; b_clear = 0; end
      fifo_rd_vld  = (fifo_q.size() > 0);
      fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
      m_awready = ($urandom_range(99) < aw_pct);
      m_wready  = ($urandom_range(99) < w_pct);
      if (!m_bvalid && b_owed > 0 && $urandom_range(99) < b_pct) begin
        m_bvalid = 1;
        m_bresp  = (b_idx == err_b_idx) ? 2'b10 : 2'b00;
      end
      #1;
      if (aw_wait) begin
        check("aw_hold", m_awvalid, 1'b1);
        check("aw_addr_stable", m_awaddr, aw_addr_prev);
        check("aw_len_stable", m_awlen, aw_len_prev);
      end
      aw_wait = m_awvalid && !m_awready;
      aw_addr_prev = m_awaddr;
      aw_len_prev  = m_awlen;
      if (m_awvalid && m_awready) begin
        aw_q.push_back({m_awaddr, m_awlen});
        cur_len = m_awlen;
        beat = 0;
      end
      check("rd_en_rule", fifo_rd_en, m_wvalid & m_wready & fifo_rd_vld);
      if (m_wvalid && m_wready) begin
        check("wlast", m_wlast, beat == cur_len);
        w_q.push_back(m_wdata);
        if (m_wlast) begin b_owed++; beat = 0; end
        else beat++;
      end
      if (fifo_rd_en && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (m_bvalid && m_bready) begin b_owed--; b_idx++; b_clear = 1; end
      if (frame_done) done_q.push_back(int'(done_frame_idx));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge rd_clk);
    #2;
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] w;
      w = $urandom;
      fifo_q.push_back(w);
      sent_q.push_back(w);
    end
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    cycles(1);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    while (done_q.size() < n && t < 2000) begin cycles(1); t++; end
    check("done_wait", done_q.size() >= n, 1'b1);
  endtask

  // Reference: the first nb bursts of frame f, straight from the frame layout rules.
  task automatic exp_bursts(input int f, input int nb);
    for (int i = 0; i < nb; i++) begin
      int wc, l;
      wc = i * BL;
      l  = (FW - wc < BL) ? FW - wc : BL;
      exp_aw.push_back({AWW'(f * STRIDE + wc * (DW / 8)), 8'(l - 1)});
    end
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_aw_cnt"}, aw_q.size(), exp_aw.size());
    for (int i = 0; i < exp_aw.size() && i < aw_q.size(); i++)
      check({tag, "_aw"}, aw_q[i], exp_aw[i]);
    check({tag, "_w_cnt"}, w_q.size(), sent_q.size());
    for (int i = 0; i < sent_q.size() && i < w_q.size(); i++)
      check({tag, "_wdata"}, w_q[i], sent_q[i]);
    aw_q.delete(); exp_aw.delete(); w_q.delete(); sent_q.delete();
  endtask

  task automatic check_done(input string tag, input int exp[$]);
    check({tag, "_done_cnt"}, done_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < done_q.size(); i++)
      check({tag, "_done_idx"}, done_q[i], exp[i]);
    done_q.delete();
  endtask

  initial begin
    int t;
    frame_start = 1'b0;
    rd_rst_n    = 1'b0;
    cycles(3);
    check("rst_awvalid", m_awvalid, 1'b0);
    check("rst_awaddr", m_awaddr, '0);
    check("rst_awlen", m_awlen, '0);
    check("rst_wvalid", m_wvalid, 1'b0);
    check("rst_wlast", m_wlast, 1'b0);
    check("rst_wstrb", m_wstrb, 4'hF);
    check("rst_bready", m_bready, 1'b0);
    check("rst_rd_en", fifo_rd_en, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_done_idx", done_frame_idx, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    rd_rst_n = 1'b1;
    cycles(2);

    // Single frame, no backpressure: 15,15,7 at 0x000/0x040/0x080.
    push_words(FW);
    start_frame();
    wait_done(1);
    exp_bursts(0, 3);
    check_stream("t1");
    check_done("t1", '{0});
    check("t1_err", err, 1'b0);
    cycles(2);
    check("t1_idle", busy, 1'b0);
    check("t1_no_pop_idle", fifo_rd_en, 1'b0);

    // Three frames; each next start lands on the DONE cycle; ring wraps to frame 0.
    push_words(3 * FW);
    start_frame();
    for (int k = 0; k < 3; k++) begin
      wait_done(k + 1);
      if (k < 2) start_frame();
    end
    exp_bursts(1, 3); exp_bursts(2, 3); exp_bursts(0, 3);
    check_stream("t2");
    check_done("t2", '{1, 2, 0});
    check("t2_err", err, 1'b0);

    // FIFO runs dry after 5 words mid-burst.
    push_words(5);
    start_frame();
    cycles(12);
    check("t3_stall_words", w_q.size(), 5);
    check("t3_stall_wvalid", m_wvalid, 1'b0);
    check("t3_stall_rd_en", fifo_rd_en, 1'b0);
    check("t3_stall_busy", busy, 1'b1);
    push_words(FW - 5);
    wait_done(1);
    exp_bursts(1, 3);
    check_stream("t3");
    check_done("t3", '{1});

    // Random backpressure on every channel, two frames.
    aw_pct = 40; w_pct = 50; b_pct = 30;
    push_words(2 * FW);
    start_frame();
    wait_done(1);
    start_frame();
    wait_done(2);
    exp_bursts(2, 3); exp_bursts(0, 3);
    check_stream("t4");
    check_done("t4", '{2, 0});
    aw_pct = 100; w_pct = 100; b_pct = 100;

    // SLVERR on the second burst: err sticks, frame still completes.
    err_b_idx = b_idx + 1;
    push_words(FW);
    start_frame();
    wait_done(1);
    exp_bursts(1, 3);
    check_stream("t5");
    check_done("t5", '{1});
    cycles(4);
    check("t5_err_sticky", err, 1'b1);
    err_b_idx = -1;

    rd_rst_n = 1'b0;
    cycles(2);
    fifo_q.delete(); sent_q.delete(); w_q.delete(); aw_q.delete(); done_q.delete();
    check("rst2_err", err, 1'b0);
    check("rst2_busy", busy, 1'b0);
    rd_rst_n = 1'b1;
    cycles(2);

    // frame_start during burst 2 abandons frame 0; new frame goes to slot 1.
    push_words(2 * BL);
    start_frame();
    t = 0;
    while (aw_q.size() < 2 && t < 500) begin cycles(1); t++; end
    check("t6_aw2_wait", aw_q.size() >= 2, 1'b1);
    start_frame();
    push_words(FW);
    wait_done(1);
    cycles(3);
    exp_bursts(0, 2); exp_bursts(1, 3);
    check_stream("t6");
    check_done("t6", '{1});
    check("t6_err", err, 1'b1);
    check("t6_done_idx", done_frame_idx, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
